// File: rtl/mips_fetch_pkg.sv
// Shared constants and types for the MIPS instruction-fetch stage.
// The optional delay-slot behaviour is selected with MIPS_FETCH_DELAY_SLOT_EN.
package mips_fetch_pkg;

   localparam logic [1:0] ST_FETCH  = 2'd0;
   localparam logic [1:0] ST_VALID  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
   localparam logic [31:0] PC_INC       = 32'd4;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
   } ifid_t;

endpackage

// File: rtl/mips_fetch_buf.sv
// One-entry IF/ID buffer: load captures a new entry, clear drops the valid bit,
// otherwise the entry holds. Clear has priority over load.
module mips_fetch_buf
   import mips_fetch_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  load,
   input  logic  clear,
   input  ifid_t load_data,
   output logic  valid,
   output ifid_t entry
);

   logic  valid_q, valid_d;
   ifid_t entry_q, entry_d;

   always_comb begin
      valid_d = valid_q;
      entry_d = entry_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         entry_d = load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         entry_q <= '0;
      end else begin
         valid_q <= valid_d;
         entry_q <= entry_d;
      end
   end

   assign valid = valid_q;
   assign entry = entry_q;

endmodule

// File: rtl/mips_fetch.sv
// MIPS fetch stage: PC, variable-latency imem requests and IF/ID handshake.
// Define MIPS_FETCH_DELAY_SLOT_EN for branch-delay-slot redirects (default: squash).
//
// state  | meaning
// FETCH  | request outstanding at pc, buffer empty
// VALID  | buffer full; overlapped fetch while decode consumes
// HALTED | no requests, buffer empty; left only by rst
module mips_fetch
   import mips_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [31:0] imem_data,
   output logic        dcd_valid,
   output logic [31:0] dcd_inst,
   output logic [31:0] dcd_pc,
   output logic [31:0] dcd_pc_plus4,
   input  logic        dcd_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        fetch_adel,
   output logic [31:0] inst_count
);

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        adel_q, adel_d;
   logic [31:0] count_q, count_d;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic        buf_load, buf_clear;
   logic        redir_take, redir_bad;
   ifid_t       buf_entry;

   assign pc_plus4  = pc_q + PC_INC;
   assign imem_req  = (state_q == ST_FETCH) | ((state_q == ST_VALID) & dcd_ready);
   assign imem_addr = pc_q;
   assign redir_bad = redirect_pc[1:0] != 2'b00;

`ifdef MIPS_FETCH_DELAY_SLOT_EN
   logic        pending_q, pending_d;
   logic [31:0] target_q, target_d;
   logic        steer;

   // A redirect seen while one is already pending is the delay slot's own and is dropped.
   assign redir_take = redirect_valid & ~pending_q;
   assign steer      = pending_q | (redir_take & ~redir_bad);
   assign next_pc    = pending_q ? target_q : (steer ? redirect_pc : pc_plus4);

   always_comb begin
      target_d  = redir_take ? redirect_pc : target_q;
      pending_d = (state_d != ST_HALTED) & steer & ~buf_load;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= 1'b0;
         target_q  <= '0;
      end else begin
         pending_q <= pending_d;
         target_q  <= target_d;
      end
   end
`else
   assign redir_take = redirect_valid;
   assign next_pc    = pc_plus4;
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      adel_d    = adel_q;
      count_d   = (dcd_valid & dcd_ready) ? count_q + 32'd1 : count_q;
      buf_load  = 1'b0;
      buf_clear = 1'b0;
      if (state_q != ST_HALTED) begin
         if (halt) begin
            state_d   = ST_HALTED;
            buf_clear = 1'b1;
         end else if (redir_take & redir_bad) begin
            adel_d    = 1'b1;
            state_d   = ST_HALTED;
            buf_clear = 1'b1;
`ifndef MIPS_FETCH_DELAY_SLOT_EN
         end else if (redirect_valid) begin
            pc_d      = redirect_pc;
            state_d   = ST_FETCH;
            buf_clear = 1'b1;
`endif
         end else begin
            case (state_q)
               ST_FETCH: begin
                  if (imem_rdy) begin
                     buf_load = 1'b1;
                     pc_d     = next_pc;
                     state_d  = ST_VALID;
                  end
               end
               ST_VALID: begin
                  if (dcd_ready) begin
                     if (imem_rdy) begin
                        buf_load = 1'b1;
                        pc_d     = next_pc;
                     end else begin
                        buf_clear = 1'b1;
                        state_d   = ST_FETCH;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         adel_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         adel_q  <= adel_d;
         count_q <= count_d;
      end
   end

   mips_fetch_buf u_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (buf_load),
      .clear     (buf_clear),
      .load_data ('{inst: imem_data, pc: pc_q, pc_plus4: pc_plus4}),
      .valid     (dcd_valid),
      .entry     (buf_entry)
   );

   assign dcd_inst     = buf_entry.inst;
   assign dcd_pc       = buf_entry.pc;
   assign dcd_pc_plus4 = buf_entry.pc_plus4;
   assign fetch_adel   = adel_q;
   assign inst_count   = count_q;

endmodule

// File: tb/tb_mips_fetch.sv
// Directed testbench for mips_fetch; memory returns addr ^ 32'hDEAD_0000.
module tb_mips_fetch;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rdy;
   logic [31:0] imem_data;
   logic        dcd_valid;
   logic [31:0] dcd_inst;
   logic [31:0] dcd_pc;
   logic [31:0] dcd_pc_plus4;
   logic        dcd_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        fetch_adel;
   logic [31:0] inst_count;

   int checks   = 0;
   int failures = 0;

   mips_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdy       (imem_rdy),
      .imem_data      (imem_data),
      .dcd_valid      (dcd_valid),
      .dcd_inst       (dcd_inst),
      .dcd_pc         (dcd_pc),
      .dcd_pc_plus4   (dcd_pc_plus4),
      .dcd_ready      (dcd_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .fetch_adel     (fetch_adel),
      .inst_count     (inst_count)
   );

   assign imem_data = imem_addr ^ 32'hDEAD_0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; imem_rdy = 1'b1; dcd_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
      step(); step();
      chk("rst_valid", {31'd0, dcd_valid}, 32'd0);
      chk("rst_inst", dcd_inst, 32'd0);
      chk("rst_pc", dcd_pc, 32'd0);
      chk("rst_pc4", dcd_pc_plus4, 32'd0);
      chk("rst_count", inst_count, 32'd0);
      chk("rst_adel", {31'd0, fetch_adel}, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd1);
      chk("rst_addr", imem_addr, 32'h0040_0000);

      // zero-latency streaming
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("str_valid", {31'd0, dcd_valid}, 32'd1);
         chk("str_pc", dcd_pc, 32'h0040_0000 + 32'(4 * i));
         chk("str_pc4", dcd_pc_plus4, 32'h0040_0004 + 32'(4 * i));
         chk("str_inst", dcd_inst, (32'h0040_0000 + 32'(4 * i)) ^ 32'hDEAD_0000);
         chk("str_addr", imem_addr, 32'h0040_0004 + 32'(4 * i));
         chk("str_count", inst_count, 32'(i));
      end
      step();
      chk("str_count4", inst_count, 32'd4);
      chk("str_pc4th", dcd_pc, 32'h0040_0010);

      // decode stall then slow memory
      dcd_ready = 1'b0; imem_rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("stall_pc", dcd_pc, 32'h0040_0010);
         chk("stall_valid", {31'd0, dcd_valid}, 32'd1);
         chk("stall_req", {31'd0, imem_req}, 32'd0);
         chk("stall_count", inst_count, 32'd4);
      end
      dcd_ready = 1'b1;
      #1;
      chk("ovl_req", {31'd0, imem_req}, 32'd1);
      chk("ovl_addr", imem_addr, 32'h0040_0014);
      step();
      chk("wait_count", inst_count, 32'd5);
      for (int i = 0; i < 2; i++) begin
         chk("wait_valid", {31'd0, dcd_valid}, 32'd0);
         chk("wait_req", {31'd0, imem_req}, 32'd1);
         chk("wait_addr", imem_addr, 32'h0040_0014);
         step();
      end
      chk("wait_held_valid", {31'd0, dcd_valid}, 32'd0);
      imem_rdy = 1'b1;
      step();
      chk("slow_valid", {31'd0, dcd_valid}, 32'd1);
      chk("slow_pc", dcd_pc, 32'h0040_0014);
      chk("slow_count", inst_count, 32'd5);

      // redirect with a response in the same cycle
      redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
      step();
      redirect_valid = 1'b0;
      chk("redir_addr", imem_addr, 32'h0040_0100);
      chk("redir_count", inst_count, 32'd6);
`ifdef MIPS_FETCH_DELAY_SLOT_EN
      chk("ds_valid", {31'd0, dcd_valid}, 32'd1);
      chk("ds_pc", dcd_pc, 32'h0040_0018);
`else
      chk("sq_valid", {31'd0, dcd_valid}, 32'd0);
`endif
      step();
      chk("tgt_valid", {31'd0, dcd_valid}, 32'd1);
      chk("tgt_pc", dcd_pc, 32'h0040_0100);
      chk("tgt_inst", dcd_inst, 32'h0040_0100 ^ 32'hDEAD_0000);
`ifdef MIPS_FETCH_DELAY_SLOT_EN
      chk("tgt_count", inst_count, 32'd7);
`else
      chk("tgt_count", inst_count, 32'd6);
`endif

      // halt mid-fetch, response in the halt cycle is dropped
      imem_rdy = 1'b0;
      step();
      chk("hf_req", {31'd0, imem_req}, 32'd1);
      chk("hf_addr", imem_addr, 32'h0040_0104);
      halt = 1'b1; imem_rdy = 1'b1;
      step();
      halt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("halt_req", {31'd0, imem_req}, 32'd0);
         chk("halt_valid", {31'd0, dcd_valid}, 32'd0);
         step();
      end
      rst = 1'b1;
      step();
      chk("rr_count", inst_count, 32'd0);
      chk("rr_addr", imem_addr, 32'h0040_0000);
      chk("rr_req", {31'd0, imem_req}, 32'd1);
      rst = 1'b0;
      step();
      chk("rr_pc", dcd_pc, 32'h0040_0000);
      chk("rr_valid", {31'd0, dcd_valid}, 32'd1);

      // misaligned redirect
      redirect_valid = 1'b1; redirect_pc = 32'h0040_0102;
      step();
      redirect_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("adel_flag", {31'd0, fetch_adel}, 32'd1);
         chk("adel_req", {31'd0, imem_req}, 32'd0);
         chk("adel_valid", {31'd0, dcd_valid}, 32'd0);
         step();
      end
      rst = 1'b1;
      step();
      chk("adel_clr", {31'd0, fetch_adel}, 32'd0);
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
